// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner: per-channel synchronizer, debouncer, edge pulses and sticky edge flags
module multi_input_conditioner #(
  parameter int CHANNELS = 4,
  parameter int COUNTERWIDTH = 3,
  parameter int WAITTIME = 3,
  parameter int SYNCSTAGES = 2,
  parameter logic [CHANNELS-1:0] RESETLEVEL = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic                anyedge,
  output logic [CHANNELS-1:0] posflag,
  output logic [CHANNELS-1:0] negflag,
  input  logic [CHANNELS-1:0] clearflags
);
  logic [CHANNELS-1:0] sync_q [SYNCSTAGES];
  logic [COUNTERWIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] sync, differ, done;
  assign sync = sync_q[SYNCSTAGES-1];
  assign differ = sync ^ conditioned;
  assign anyedge = |{positiveedge, negativeedge};
  always_comb begin
    done = '0;
    for (int c = 0; c < CHANNELS; c++) done[c] = differ[c] && cnt[c] == COUNTERWIDTH'(WAITTIME);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNCSTAGES; s++) sync_q[s] <= RESETLEVEL;
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      conditioned <= RESETLEVEL;
      positiveedge <= '0;
      negativeedge <= '0;
      posflag <= '0;
      negflag <= '0;
    end else begin
      sync_q[0] <= noisysignal;
      for (int s = 1; s < SYNCSTAGES; s++) sync_q[s] <= sync_q[s-1];
      // counter only runs while the input disagrees and stops at WAITTIME, so it never wraps
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= (differ[c] && !done[c]) ? cnt[c] + 1'b1 : '0;
      conditioned <= conditioned ^ done;
      positiveedge <= done & sync;
      negativeedge <= done & ~sync;
      posflag <= (done & sync) | (posflag & ~clearflags);
      negflag <= (done & ~sync) | (negflag & ~clearflags);
    end
  end
endmodule
